// File: rtl/minibus_master_ctrl.sv
// Single-outstanding minibus master: turns one core load/store into one bus
// transaction with alignment checks, load extension and a bus timeout.
module minibus_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_wen,
    input  logic [1:0]            cpu_req_width,
    input  logic                  cpu_req_signed,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [1:0]            cpu_resp_code,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                  bus_sel,
    output logic                  bus_wen,
    output logic                  bus_ren,
    output logic [1:0]            bus_width,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic                  bus_err,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam int             CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_BUS_ERR = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_ALIGN   = 2'b11;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  req_signed, req_signed_nxt;
    logic                  ready_nxt, resp_valid_nxt;
    logic [1:0]            resp_code_nxt;
    logic [DATA_WIDTH-1:0] resp_rdata_nxt;
    logic                  sel_nxt, wen_nxt, ren_nxt;
    logic [1:0]            width_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;

    function automatic logic misaligned(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mask_wdata(input logic [1:0] w,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (w)
            2'b00:   mask_wdata = DATA_WIDTH'(d[7:0]);
            2'b01:   mask_wdata = DATA_WIDTH'(d[15:0]);
            default: mask_wdata = d;
        endcase
    endfunction

    // Slave data is right-justified; only the addressed lanes are trusted.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [1:0] w, input logic s,
                                                          input logic [DATA_WIDTH-1:0] d);
        case (w)
            2'b00:   extend_load = {{(DATA_WIDTH-8){s & d[7]}}, d[7:0]};
            2'b01:   extend_load = {{(DATA_WIDTH-16){s & d[15]}}, d[15:0]};
            default: extend_load = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state          <= IDLE;
            cnt            <= '0;
            req_signed     <= 1'b0;
            cpu_req_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_code  <= 2'b00;
            cpu_resp_rdata <= '0;
            bus_sel        <= 1'b0;
            bus_wen        <= 1'b0;
            bus_ren        <= 1'b0;
            bus_width      <= 2'b00;
            bus_addr       <= '0;
            bus_wdata      <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            req_signed     <= req_signed_nxt;
            cpu_req_ready  <= ready_nxt;
            cpu_resp_valid <= resp_valid_nxt;
            cpu_resp_code  <= resp_code_nxt;
            cpu_resp_rdata <= resp_rdata_nxt;
            bus_sel        <= sel_nxt;
            bus_wen        <= wen_nxt;
            bus_ren        <= ren_nxt;
            bus_width      <= width_nxt;
            bus_addr       <= addr_nxt;
            bus_wdata      <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        req_signed_nxt = req_signed;
        ready_nxt      = cpu_req_ready;
        resp_valid_nxt = 1'b0;
        resp_code_nxt  = cpu_resp_code;
        resp_rdata_nxt = cpu_resp_rdata;
        sel_nxt        = bus_sel;
        wen_nxt        = bus_wen;
        ren_nxt        = bus_ren;
        width_nxt      = bus_width;
        addr_nxt       = bus_addr;
        wdata_nxt      = bus_wdata;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (cpu_req_valid && cpu_req_ready) begin
                    ready_nxt      = 1'b0;
                    req_signed_nxt = cpu_req_signed;
                    if (misaligned(cpu_req_width, cpu_req_addr[1:0])) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_code_nxt  = CODE_ALIGN;
                        resp_rdata_nxt = '0;
                    end else begin
                        state_nxt = BUS;
                        cnt_nxt   = '0;
                        sel_nxt   = 1'b1;
                        wen_nxt   = cpu_req_wen;
                        ren_nxt   = ~cpu_req_wen;
                        width_nxt = cpu_req_width;
                        addr_nxt  = cpu_req_addr;
                        wdata_nxt = mask_wdata(cpu_req_width, cpu_req_wdata);
                    end
                end
            end
            BUS: begin
                // err beats ack beats timeout; the latched bus_wen/bus_width stay valid here.
                if (bus_err || bus_ack || cnt == CNT_MAX) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = '0;
                    sel_nxt        = 1'b0;
                    wen_nxt        = 1'b0;
                    ren_nxt        = 1'b0;
                    if (bus_err) begin
                        resp_code_nxt = CODE_BUS_ERR;
                    end else if (bus_ack) begin
                        resp_code_nxt = CODE_OK;
                        if (!bus_wen)
                            resp_rdata_nxt = extend_load(bus_width, req_signed, bus_rdata);
                    end else begin
                        resp_code_nxt = CODE_TIMEOUT;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_minibus_master_ctrl.sv
// Self-checking bench for minibus_master_ctrl: directed table, hand sequences
// for reset/stray-ack corners, and random transactions against a reference model.
module tb_minibus_master_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_wen = 1'b0;
    logic [1:0]  cpu_req_width = 2'b00;
    logic        cpu_req_signed = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_resp_valid;
    logic [1:0]  cpu_resp_code;
    logic [31:0] cpu_resp_rdata;
    logic        bus_sel, bus_wen, bus_ren;
    logic [1:0]  bus_width;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    minibus_master_ctrl #(.TIMEOUT_CYCLES(TO), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_wen(cpu_req_wen), .cpu_req_width(cpu_req_width),
        .cpu_req_signed(cpu_req_signed), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_code(cpu_resp_code),
        .cpu_resp_rdata(cpu_resp_rdata),
        .bus_sel(bus_sel), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_width(bus_width), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // slave response kinds
    localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

    typedef struct {
        string       name;
        bit          wen;
        logic [1:0]  width;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          d;
        int          kind;
        logic [1:0]  exp_code;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_sel;
    } vec_t;

    // results of the last run_txn
    logic [1:0]  r_code;
    logic [31:0] r_rdata;
    int          r_lat, r_sel;
    bit          r_busok, r_ready, r_pulse, r_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: outcome from the request and slave behaviour, in plain arithmetic.
    function automatic void model(input bit wen, input logic [1:0] width, input bit sgn,
                                  input logic [31:0] addr, input logic [31:0] rd,
                                  input int d, input int kind,
                                  output logic [1:0] code, output logic [31:0] rdata,
                                  output int lat, output int sel);
        int bits;
        longint v;
        rdata = 0;
        if (width == 2'd3 || (addr % (1 << width)) != 0) begin
            code = 2'd3; lat = 1; sel = 0; return;
        end
        if (kind == K_NONE || d > TO) begin
            code = 2'd2; lat = TO + 1; sel = TO; return;
        end
        lat = d + 1; sel = d;
        if (kind != K_ACK) begin
            code = 2'd1; return;
        end
        code = 2'd0;
        if (!wen) begin
            bits = 8 << width;
            v = longint'(rd) % (64'sd1 << bits);
            if (sgn && v >= (64'sd1 << (bits - 1))) v = v - (64'sd1 << bits);
            rdata = v[31:0];
        end
    endfunction

    // Called at a negedge. Slave answers in the d-th cycle it sees bus_sel.
    task automatic run_txn(input bit wen, input logic [1:0] width, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input int d, input int kind);
        int c;
        bit got;
        logic [31:0] exp_wd;
        exp_wd = (width == 2'd3) ? wdata : 32'(longint'(wdata) % (64'sd1 << (8 << width)));
        c = 0;
        while (!cpu_req_ready && c < 50) begin @(negedge clk); c++; end
        r_lat = -1; r_sel = 0; r_busok = 1'b1; got = 1'b0;
        r_code = 'x; r_rdata = 'x; r_ready = 1'b0; r_pulse = 1'b1; r_hold = 1'b0;
        if (!cpu_req_ready) begin
            tests++; fails++;
            $display("FAIL ready_wait: cpu_req_ready still 0 after 50 cycles, required 1");
            return;
        end
        cpu_req_valid = 1'b1; cpu_req_wen = wen; cpu_req_width = width;
        cpu_req_signed = sgn; cpu_req_addr = addr; cpu_req_wdata = wdata;
        bus_rdata = rd;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_wdata = $urandom;
        for (c = 1; c <= 40 && !got; c++) begin
            if (cpu_resp_valid) begin
                got = 1'b1; r_lat = c; r_code = cpu_resp_code; r_rdata = cpu_resp_rdata;
            end
            if (bus_sel) begin
                r_sel++;
                if (bus_wen !== wen || bus_ren !== !wen || bus_addr !== addr ||
                    bus_width !== width || bus_wdata !== exp_wd) r_busok = 1'b0;
            end else if (bus_wen || bus_ren) begin
                r_busok = 1'b0;
            end
            bus_ack = bus_sel && r_sel == d && (kind == K_ACK || kind == K_BOTH);
            bus_err = bus_sel && r_sel == d && (kind == K_ERR || kind == K_BOTH);
            @(negedge clk);
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL resp_wait: no cpu_resp_valid within 40 cycles, required a response");
            return;
        end
        r_ready = cpu_req_ready;
        r_pulse = cpu_resp_valid;
        r_hold  = (cpu_resp_code === r_code) && (cpu_resp_rdata === r_rdata);
    endtask

    task automatic check_txn(input string n, input logic [1:0] code, input logic [31:0] rdata,
                             input int lat, input int sel);
        if (r_lat < 0) return;
        check({n, ".code"}, 32'(r_code), 32'(code));
        check({n, ".rdata"}, r_rdata, rdata);
        check({n, ".latency"}, r_lat, lat);
        check({n, ".sel_cycles"}, r_sel, sel);
        check({n, ".bus_fields"}, 32'(r_busok), 32'd1);
        check({n, ".ready_after"}, 32'(r_ready), 32'd1);
        check({n, ".single_pulse"}, 32'(r_pulse), 32'd0);
        check({n, ".resp_hold"}, 32'(r_hold), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [1:0]  m_code;
        logic [31:0] m_rdata;
        int          m_lat, m_sel;

        vecs.push_back('{"st_word",    1, 2'd2, 0, 32'h8, 32'hDEADBEEF, 32'h0,        2, K_ACK,  2'd0, 32'h0,        3, 2});
        vecs.push_back('{"ld_sbyte",   0, 2'd0, 1, 32'h3, 32'h0,        32'h80,       2, K_ACK,  2'd0, 32'hFFFFFF80, 3, 2});
        vecs.push_back('{"ld_ubyte",   0, 2'd0, 0, 32'h3, 32'h0,        32'h80,       2, K_ACK,  2'd0, 32'h00000080, 3, 2});
        vecs.push_back('{"ld_shalf",   0, 2'd1, 1, 32'h2, 32'h0,        32'h7FFF,     2, K_ACK,  2'd0, 32'h00007FFF, 3, 2});
        vecs.push_back('{"ld_shalf_n", 0, 2'd1, 1, 32'h6, 32'h0,        32'h8001,     3, K_ACK,  2'd0, 32'hFFFF8001, 4, 3});
        vecs.push_back('{"st_half_mis",1, 2'd1, 0, 32'h5, 32'h1234,     32'h0,        2, K_ACK,  2'd3, 32'h0,        1, 0});
        vecs.push_back('{"width11",    0, 2'd3, 0, 32'h0, 32'h0,        32'h0,        2, K_ACK,  2'd3, 32'h0,        1, 0});
        vecs.push_back('{"word_mis",   0, 2'd2, 0, 32'h2, 32'h0,        32'h0,        2, K_ACK,  2'd3, 32'h0,        1, 0});
        vecs.push_back('{"timeout",    0, 2'd2, 0, 32'h10,32'h0,        32'hAAAA5555, 0, K_NONE, 2'd2, 32'h0,       17, 16});
        vecs.push_back('{"ack_err",    0, 2'd2, 0, 32'h4, 32'h0,        32'hCAFEF00D, 2, K_BOTH, 2'd1, 32'h0,        3, 2});
        vecs.push_back('{"err_fast",   1, 2'd0, 0, 32'h1, 32'hFF,       32'h0,        1, K_ERR,  2'd1, 32'h0,        2, 1});
        vecs.push_back('{"ack_last",   0, 2'd2, 0, 32'hC, 32'h0,        32'h12345678,16, K_ACK,  2'd0, 32'h12345678,17, 16});
        vecs.push_back('{"st_byte",    1, 2'd0, 0, 32'h7, 32'hA5A5A5C3, 32'hFFFFFFFF, 2, K_ACK,  2'd0, 32'h0,        3, 2});

        // reset state
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(cpu_req_ready), 32'd0);
        check("rst.resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst.resp_code", 32'(cpu_resp_code), 32'd0);
        check("rst.resp_rdata", cpu_resp_rdata, 32'd0);
        check("rst.bus_strobes", {29'd0, bus_sel, bus_wen, bus_ren}, 32'd0);
        check("rst.bus_addr", bus_addr, 32'd0);
        check("rst.bus_wdata", bus_wdata, 32'd0);
        check("rst.bus_width", 32'(bus_width), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst.ready_rise", 32'(cpu_req_ready), 32'd1);

        foreach (vecs[i]) begin
            run_txn(vecs[i].wen, vecs[i].width, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rd, vecs[i].d, vecs[i].kind);
            check_txn(vecs[i].name, vecs[i].exp_code, vecs[i].exp_rdata,
                      vecs[i].exp_lat, vecs[i].exp_sel);
        end

        // stray ack/err while idle
        for (int k = 0; k < 3; k++) begin
            bus_ack = 1'b1; bus_err = (k == 1);
            @(negedge clk);
            check("stray.resp_valid", 32'(cpu_resp_valid), 32'd0);
            check("stray.bus_sel", 32'(bus_sel), 32'd0);
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        check("stray.ready", 32'(cpu_req_ready), 32'd1);

        // reset while the transaction is on the bus
        cpu_req_valid = 1'b1; cpu_req_wen = 1'b0; cpu_req_width = 2'd2; cpu_req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        check("midrst.sel_T1", 32'(bus_sel), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        check("midrst.sel", 32'(bus_sel), 32'd0);
        check("midrst.ren", 32'(bus_ren), 32'd0);
        check("midrst.resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("midrst.ready", 32'(cpu_req_ready), 32'd0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("midrst.ready_hold", 32'(cpu_req_ready), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("midrst.ready_rise", 32'(cpu_req_ready), 32'd1);
        check("midrst.no_resp", 32'(cpu_resp_valid), 32'd0);
        check("midrst.sel_low", 32'(bus_sel), 32'd0);

        // random transactions against the model
        for (int n = 0; n < 60; n++) begin
            bit          wen, sgn;
            logic [1:0]  width;
            logic [31:0] addr, wdata, rd;
            int          d, kind, r;
            wen = 1'($urandom); sgn = 1'($urandom);
            width = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wdata = $urandom; rd = $urandom;
            d = $urandom_range(1, TO + 2);
            r = $urandom_range(0, 9);
            kind = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r == 8) ? K_BOTH : K_NONE;
            model(wen, width, sgn, addr, rd, d, kind, m_code, m_rdata, m_lat, m_sel);
            run_txn(wen, width, sgn, addr, wdata, rd, d, kind);
            check_txn($sformatf("rnd%0d", n), m_code, m_rdata, m_lat, m_sel);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/minibus_master_ctrl.md
# minibus_master_ctrl

Single-outstanding minibus master that turns a core-side load/store request into one minibus transaction and returns a registered response. Sits between the CPU memory stage (or a debug/DMA requester) and the minibus slave fabric; drives sel/req toward slaves such as the register-array slave and consumes their ack/err/rdata. Adds alignment checking, load sign-extension and a bus timeout so a missing slave can never hang the core.

## Interface
- TIMEOUT_CYCLES, 16: max BUS-state cycles without ack/err before a timeout error (≥2)
- DATA_WIDTH / ADDR_WIDTH: from minibus_pkg (32 / 32)

- clk  in  1  clock; all logic on posedge
- nrst  in  1  reset, synchronous, active-low
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  request accepted when valid & ready
- cpu_req_wen  in  1  1 = store, 0 = load
- cpu_req_width  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_req_signed  in  1  sign-extend load data
- cpu_req_addr  in  ADDR_WIDTH  byte address
- cpu_req_wdata  in  DATA_WIDTH  store data, right-justified
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_code  out  2  00 ok, 01 bus err, 10 timeout, 11 misaligned/illegal width
- cpu_resp_rdata  out  DATA_WIDTH  load data (0 for stores/errors)
- bus_sel  out  1  slave select
- bus_wen / bus_ren  out  1 each  write / read strobe
- bus_width  out  2  copy of request width
- bus_addr  out  ADDR_WIDTH  byte address
- bus_wdata  out  DATA_WIDTH  store data, unused upper bytes zeroed
- bus_ack  in  1  slave acknowledge
- bus_err  in  1  slave error
- bus_rdata  in  DATA_WIDTH  read data, right-justified, zero-extended by slave

## Operation
- States: IDLE, BUS, RESP. All outputs registered.
- IDLE: cpu_req_ready=1. On valid&ready latch request. If width=11, or width=01 with addr[0]=1, or width=10 with addr[1:0]≠0 → RESP with code 11, no bus activity. Else → BUS with bus_sel=1, bus_wen=wen, bus_ren=~wen, width/addr/wdata driven from latch; timeout counter cleared.
- Write data masking: byte → wdata[7:0] only, half → wdata[15:0] only, upper bits 0.
- BUS: request held stable every cycle. Counter increments each BUS cycle. Priority per cycle: bus_err → RESP code 01; else bus_ack → RESP code 00, capture rdata; else counter = TIMEOUT_CYCLES-1 → RESP code 10. Leaving BUS clears bus_sel/wen/ren on the same edge.
- rdata capture (loads only): byte → bus_rdata[7:0], extend bit 7 if signed else zero; half → [15:0], extend bit 15 if signed; word → as is. Stores and errors → rdata 0.
- RESP: cpu_resp_valid=1 for exactly one cycle with code/rdata; cpu_req_ready=0; → IDLE. Code/rdata hold until next response.
- bus_ack/bus_err outside BUS are ignored.

## Timing
- Reset (nrst=0 at posedge): state IDLE, counter 0, every output 0 (including cpu_req_ready); ready rises the first cycle after reset release.
- Reset mid-transaction: bus_sel/wen/ren drop at that edge, no response issued, request discarded.
- Accept at edge T0 → bus_sel high cycle T1; slave with registered ack returns ack in T2 → cpu_resp_valid in T3. Minimum accept-to-response 3 cycles; misaligned/illegal: 1 cycle (resp_valid in T1).
- Timeout: resp_valid exactly TIMEOUT_CYCLES+1 cycles after accept if slave never responds.
- Back-to-back: next request accepted in the cycle after RESP; max throughput one transaction per 4 cycles with 1-wait slave.
- ack and err in same cycle → code 01, rdata 0.

## Test plan
- Word store 0xDEADBEEF to addr 0x8, slave acks in T2 → bus_sel high T1–T2, bus_wen=1, resp_valid T3 code 00 rdata 0; ready back T4.
- Signed byte load addr 0x3, slave returns 0x00000080 → rdata 0xFFFFFF80; same unsigned → 0x00000080; signed half returning 0x00007FFF → 0x00007FFF.
- Half store addr 0x5 → resp_valid next cycle code 11, bus_sel never asserted; width=11 likewise code 11.
- No slave response, TIMEOUT_CYCLES=16 → bus_sel high 16 cycles, resp code 10 at T17, bus_sel low.
- Slave asserts ack and err together → code 01; stray bus_ack in IDLE → no resp_valid.
- nrst low during BUS (cycle T1) → bus_sel 0 next cycle, no resp_valid, cpu_req_ready 0 until release then 1.
